// File: rtl/writeback_stage_if.sv
// -----------------------------------------------------------------------------
// writeback_stage_if
// Bundles everything that crosses the boundary of the write-back stage except
// clock and reset: the instruction handed over by EX, the data-memory read
// response, and the write-back bus plus stall and retirement count.
//
// Handshake semantics:
//   EX -> WB : an instruction is transferred on a rising edge where
//              ex_valid_i=1 and stall_o=0. While stall_o=1, EX keeps its
//              instruction (and ex_valid_i) stable; the stage ignores it.
//   dmem->WB : dmem_rvalid_i is a single-cycle strobe with dmem_rdata_i
//              valid in the same cycle. There is no back-pressure toward
//              dmem; the strobe is consumed only while a load is outstanding.
//   WB -> RF : wb_reg_write_o is a one-cycle pulse; wb_rd_o/wb_data_o keep
//              their last values between pulses.
//
// Modports:
//   master : the pipeline/memory side (drives ex_*, dmem_*)
//   slave  : the write-back stage itself
// -----------------------------------------------------------------------------
interface writeback_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
);
  logic             ex_valid_i;
  logic             ex_reg_write_i;
  logic [4:0]       ex_rd_i;
  logic [XLEN-1:0]  ex_result_i;
  logic             ex_mem_read_i;
  logic [1:0]       ex_mem_size_i;
  logic             ex_mem_unsigned_i;
  logic [1:0]       ex_addr_lsb_i;
  logic             dmem_rvalid_i;
  logic [XLEN-1:0]  dmem_rdata_i;
  logic             stall_o;
  logic             wb_reg_write_o;
  logic [4:0]       wb_rd_o;
  logic [XLEN-1:0]  wb_data_o;
  logic [CNT_W-1:0] instret_o;

  modport master (
    output ex_valid_i, ex_reg_write_i, ex_rd_i, ex_result_i, ex_mem_read_i,
           ex_mem_size_i, ex_mem_unsigned_i, ex_addr_lsb_i,
           dmem_rvalid_i, dmem_rdata_i,
    input  stall_o, wb_reg_write_o, wb_rd_o, wb_data_o, instret_o
  );

  modport slave (
    input  ex_valid_i, ex_reg_write_i, ex_rd_i, ex_result_i, ex_mem_read_i,
           ex_mem_size_i, ex_mem_unsigned_i, ex_addr_lsb_i,
           dmem_rvalid_i, dmem_rdata_i,
    output stall_o, wb_reg_write_o, wb_rd_o, wb_data_o, instret_o
  );
endinterface

// File: rtl/writeback_stage.sv
// -----------------------------------------------------------------------------
// writeback_stage
// Final pipeline stage. Registers each instruction leaving EX, waits for
// data-memory read data on loads, aligns and sign/zero-extends it, and drives
// the write-back bus shared by the register file and the forwarding unit.
// Stalls upstream while a load is outstanding and counts retirements.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       synchronous active-low reset
//   bus          writeback_stage_if.slave (EX input, dmem response, wb bus,
//                stall, instret)
//   dbg_state_o  FSM state (0 = RUN, 1 = WAIT)
// -----------------------------------------------------------------------------
module writeback_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  writeback_stage_if.slave  bus,
  output logic              dbg_state_o
);

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [4:0]       ld_rd_q, ld_rd_d;
  logic             ld_we_q, ld_we_d;
  logic [1:0]       ld_size_q, ld_size_d;
  logic             ld_uns_q, ld_uns_d;
  logic [1:0]       ld_lsb_q, ld_lsb_d;
  logic             wb_we_q, wb_we_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]  wb_data_q, wb_data_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [XLEN-1:0]  load_data;

  // Load alignment uses the fields captured at accept, so dmem_rdata_i only
  // has to be valid alongside dmem_rvalid_i.
  always_comb begin
    byte_sel  = 8'h00;
    half_sel  = 16'h0000;
    load_data = '0;
    case (ld_lsb_q)
      2'd0:    byte_sel = bus.dmem_rdata_i[7:0];
      2'd1:    byte_sel = bus.dmem_rdata_i[15:8];
      2'd2:    byte_sel = bus.dmem_rdata_i[23:16];
      default: byte_sel = bus.dmem_rdata_i[31:24];
    endcase
    half_sel = ld_lsb_q[1] ? bus.dmem_rdata_i[31:16] : bus.dmem_rdata_i[15:0];
    case (ld_size_q)
      2'b00:   load_data = {{(XLEN-8){~ld_uns_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_data = {{(XLEN-16){~ld_uns_q & half_sel[15]}}, half_sel};
      default: load_data = bus.dmem_rdata_i;  // 10 and 11 are both word
    endcase
  end

  always_comb begin
    state_d   = state_q;
    ld_rd_d   = ld_rd_q;
    ld_we_d   = ld_we_q;
    ld_size_d = ld_size_q;
    ld_uns_d  = ld_uns_q;
    ld_lsb_d  = ld_lsb_q;
    wb_we_d   = 1'b0;  // pulse: low unless something retires with a write
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    instret_d = instret_q;
    case (state_q)
      RUN: begin
        if (bus.ex_valid_i) begin
          if (bus.ex_mem_read_i) begin
            ld_rd_d   = bus.ex_rd_i;
            ld_we_d   = bus.ex_reg_write_i;
            ld_size_d = bus.ex_mem_size_i;
            ld_uns_d  = bus.ex_mem_unsigned_i;
            ld_lsb_d  = bus.ex_addr_lsb_i;
            state_d   = WAIT;
          end else begin
            // x0 must never be written: the forwarding unit trusts this bus.
            wb_we_d   = bus.ex_reg_write_i & (bus.ex_rd_i != 5'd0);
            wb_rd_d   = bus.ex_rd_i;
            wb_data_d = bus.ex_result_i;
            instret_d = instret_q + CNT_ONE;
          end
        end
      end
      WAIT: begin
        if (bus.dmem_rvalid_i) begin
          wb_we_d   = ld_we_q & (ld_rd_q != 5'd0);
          wb_rd_d   = ld_rd_q;
          wb_data_d = load_data;
          instret_d = instret_q + CNT_ONE;
          state_d   = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= RUN;
      ld_rd_q   <= 5'd0;
      ld_we_q   <= 1'b0;
      ld_size_q <= 2'b00;
      ld_uns_q  <= 1'b0;
      ld_lsb_q  <= 2'b00;
      wb_we_q   <= 1'b0;
      wb_rd_q   <= 5'd0;
      wb_data_q <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      ld_rd_q   <= ld_rd_d;
      ld_we_q   <= ld_we_d;
      ld_size_q <= ld_size_d;
      ld_uns_q  <= ld_uns_d;
      ld_lsb_q  <= ld_lsb_d;
      wb_we_q   <= wb_we_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      instret_q <= instret_d;
    end
  end

  // Stall is a pure state decode so it has no input-to-output path.
  assign bus.stall_o        = (state_q == WAIT);
  assign bus.wb_reg_write_o = wb_we_q;
  assign bus.wb_rd_o        = wb_rd_q;
  assign bus.wb_data_o      = wb_data_q;
  assign bus.instret_o      = instret_q;
  assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dbg_state;
  always #5 clk = ~clk;

  writeback_stage_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  writeback_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Load value from word, access width in bytes and offset, by arithmetic.
  function automatic logic [31:0] load_value(input logic [31:0] w, input logic [1:0] size,
                                             input logic uns, input logic [1:0] lsb);
    longint nbytes, off, v, top;
    nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    off    = (nbytes == 1) ? longint'(lsb) : (nbytes == 2) ? longint'(lsb & 2'b10) : 0;
    v      = longint'(w) / (64'd1 << (8 * off));
    v      = v % (64'd1 << (8 * nbytes));
    top    = 64'd1 << (8 * nbytes - 1);
    if (!uns && v >= top) v = v - 2 * top;
    return v[31:0];
  endfunction

  logic        m_wait = 1'b0;
  logic        m_we = 1'b0;
  logic [4:0]  m_rd = 5'd0;
  logic [31:0] m_data = 32'd0;
  int          m_cnt = 0;
  logic [4:0]  p_rd;
  logic        p_we;
  logic [1:0]  p_size;
  logic        p_uns;
  logic [1:0]  p_lsb;
  logic        model_live = 1'b0;

  always @(posedge clk) begin
    model_live = 1'b1;
    m_we = 1'b0;
    if (!rst_n) begin
      m_wait = 1'b0; m_rd = 5'd0; m_data = 32'd0; m_cnt = 0;
    end else if (m_wait) begin
      if (bus.dmem_rvalid_i) begin
        m_we   = p_we && (p_rd != 0);
        m_rd   = p_rd;
        m_data = load_value(bus.dmem_rdata_i, p_size, p_uns, p_lsb);
        m_cnt  = (m_cnt + 1) % (1 << CNT_W);
        m_wait = 1'b0;
      end
    end else if (bus.ex_valid_i) begin
      if (bus.ex_mem_read_i) begin
        p_rd = bus.ex_rd_i; p_we = bus.ex_reg_write_i; p_size = bus.ex_mem_size_i;
        p_uns = bus.ex_mem_unsigned_i; p_lsb = bus.ex_addr_lsb_i;
        m_wait = 1'b1;
      end else begin
        m_we   = bus.ex_reg_write_i && (bus.ex_rd_i != 0);
        m_rd   = bus.ex_rd_i;
        m_data = bus.ex_result_i;
        m_cnt  = (m_cnt + 1) % (1 << CNT_W);
      end
    end
  end

  // ---------------- compare process (every cycle) ----------------
  always @(posedge clk) begin
    #1;
    if (model_live) begin
      check("stall", 64'(bus.stall_o), 64'(m_wait));
      check("state", 64'(dbg_state), 64'(m_wait));
      check("wb_we", 64'(bus.wb_reg_write_o), 64'(m_we));
      check("wb_rd", 64'(bus.wb_rd_o), 64'(m_rd));
      check("wb_data", 64'(bus.wb_data_o), 64'(m_data));
      check("instret", 64'(bus.instret_o), 64'(m_cnt));
    end
  end

  // ---------------- driver tasks (call at negedge) ----------------
  task automatic drv_idle();
    bus.ex_valid_i = 1'b0; bus.ex_mem_read_i = 1'b0; bus.dmem_rvalid_i = 1'b0;
  endtask

  task automatic drv_op(input logic [4:0] rd, input logic [31:0] res, input logic we);
    bus.ex_valid_i = 1'b1; bus.ex_mem_read_i = 1'b0; bus.ex_reg_write_i = we;
    bus.ex_rd_i = rd; bus.ex_result_i = res;
  endtask

  task automatic drv_ld(input logic [4:0] rd, input logic [1:0] size, input logic uns,
                        input logic [1:0] lsb);
    bus.ex_valid_i = 1'b1; bus.ex_mem_read_i = 1'b1; bus.ex_reg_write_i = 1'b1;
    bus.ex_rd_i = rd; bus.ex_mem_size_i = size; bus.ex_mem_unsigned_i = uns;
    bus.ex_addr_lsb_i = lsb; bus.ex_result_i = 32'hDEAD_BEEF;
  endtask

  task automatic drv_rvalid(input logic v, input logic [31:0] d);
    bus.dmem_rvalid_i = v; bus.dmem_rdata_i = d;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic half_load(input logic uns, input logic [31:0] exp);
    step(); drv_ld(5'd12, 2'b01, uns, 2'd2);
    step(); drv_idle(); drv_rvalid(1'b1, 32'h8001_0000);
    step(); drv_rvalid(1'b0, 32'h0);
    check("half_data", 64'(bus.wb_data_o), 64'(exp));
    check("half_we", 64'(bus.wb_reg_write_o), 64'd1);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    drv_idle();
    bus.ex_reg_write_i = 1'b0; bus.ex_rd_i = 5'd0; bus.ex_result_i = 32'd0;
    bus.ex_mem_size_i = 2'b00; bus.ex_mem_unsigned_i = 1'b0; bus.ex_addr_lsb_i = 2'd0;
    bus.dmem_rdata_i = 32'd0;

    repeat (3) step();
    rst_n = 1'b1;
    check("rst_stall", 64'(bus.stall_o), 64'd0);
    check("rst_instret", 64'(bus.instret_o), 64'd0);

    // Back-to-back non-loads, third targets x0
    drv_op(5'd5, 32'h11, 1'b1);
    step(); drv_op(5'd6, 32'h22, 1'b1);
    check("b2b_1_we", 64'(bus.wb_reg_write_o), 64'd1);
    check("b2b_1_data", 64'(bus.wb_data_o), 64'h11);
    step(); drv_op(5'd0, 32'h33, 1'b1);
    check("b2b_2_rd", 64'(bus.wb_rd_o), 64'd6);
    check("b2b_2_data", 64'(bus.wb_data_o), 64'h22);
    step(); drv_idle();
    check("b2b_x0_we", 64'(bus.wb_reg_write_o), 64'd0);
    check("b2b_x0_rd", 64'(bus.wb_rd_o), 64'd0);
    check("b2b_instret", 64'(bus.instret_o), 64'd3);

    // Signed byte load, rvalid three cycles after accept
    step(); drv_ld(5'd7, 2'b00, 1'b0, 2'd2);
    step(); drv_op(5'd9, 32'h99, 1'b1);  // next instruction held in EX
    check("lb_stall1", 64'(bus.stall_o), 64'd1);
    step(); check("lb_stall2", 64'(bus.stall_o), 64'd1);
    step(); check("lb_stall3", 64'(bus.stall_o), 64'd1);
    drv_rvalid(1'b1, 32'h80FF_1234);
    step(); drv_rvalid(1'b0, 32'h0);
    check("lb_stall_off", 64'(bus.stall_o), 64'd0);
    check("lb_we", 64'(bus.wb_reg_write_o), 64'd1);
    check("lb_rd", 64'(bus.wb_rd_o), 64'd7);
    check("lb_data", 64'(bus.wb_data_o), 64'hFFFF_FFFF);
    step(); drv_idle();
    check("held_op_data", 64'(bus.wb_data_o), 64'h99);

    // Halfword loads
    half_load(1'b1, 32'h0000_8001);
    half_load(1'b0, 32'hFFFF_8001);

    // Zero-wait load with dependent ADD held in EX
    step(); drv_ld(5'd8, 2'b10, 1'b0, 2'd3);
    step(); drv_op(5'd9, 32'hAA, 1'b1); drv_rvalid(1'b1, 32'h1234_5678);
    check("lu_stall", 64'(bus.stall_o), 64'd1);
    step(); drv_rvalid(1'b0, 32'h0);
    check("lu_stall_off", 64'(bus.stall_o), 64'd0);
    check("lu_rd", 64'(bus.wb_rd_o), 64'd8);
    check("lu_data", 64'(bus.wb_data_o), 64'h1234_5678);
    step(); drv_idle();
    check("lu_add_data", 64'(bus.wb_data_o), 64'hAA);

    // Reset held 3 cycles while in WAIT, then a stray rvalid
    step(); drv_ld(5'd10, 2'b10, 1'b0, 2'd0);
    step(); drv_idle(); rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    check("rstw_stall", 64'(bus.stall_o), 64'd0);
    check("rstw_data", 64'(bus.wb_data_o), 64'd0);
    drv_rvalid(1'b1, 32'hCAFE_F00D);
    step(); drv_rvalid(1'b0, 32'h0);
    check("stray_we", 64'(bus.wb_reg_write_o), 64'd0);
    check("stray_stall", 64'(bus.stall_o), 64'd0);
    check("stray_instret", 64'(bus.instret_o), 64'd0);

    // 16 retirements (stores/branches mixed in) wrap a 4-bit counter
    for (int i = 0; i < 16; i++) begin
      drv_op(5'(i + 1), 32'(i * 3), (i % 3) != 0);
      step();
      if (i == 14) check("cnt_15", 64'(bus.instret_o), 64'd15);
    end
    drv_idle();
    check("cnt_wrap", 64'(bus.instret_o), 64'd0);
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final stage of the core pipeline. Registers each instruction leaving EX, waits for data-memory read data on loads, aligns and sign/zero-extends load data, and drives the write-back bus (`wb_reg_write_o`, `wb_rd_o`, `wb_data_o`). That bus feeds both the register file write port and the forwarding unit's WB operand path. The block also stalls upstream stages while a load is outstanding and keeps the retired-instruction counter.

## Interface
Parameters:
- `XLEN`, 32: datapath width.
- `CNT_W`, 64: width of the retired-instruction counter.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  reset, synchronous and active-low.
- `ex_valid_i`  in  1  EX presents an instruction this cycle.
- `ex_reg_write_i`  in  1  instruction writes rd.
- `ex_rd_i`  in  5  destination register.
- `ex_result_i`  in  XLEN  non-load result (ALU, PC+4, LUI/AUIPC value).
- `ex_mem_read_i`  in  1  instruction is a load; the dmem request was issued by EX in the same cycle.
- `ex_mem_size_i`  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as word.
- `ex_mem_unsigned_i`  in  1  zero-extend (LBU/LHU).
- `ex_addr_lsb_i`  in  2  load address[1:0].
- `dmem_rvalid_i`  in  1  read data valid.
- `dmem_rdata_i`  in  XLEN  raw 32-bit word read from dmem.
- `stall_o`  out  1  freeze IF/EX; EX holds its instruction.
- `wb_reg_write_o`  out  1  write-enable, one-cycle pulse per writing instruction.
- `wb_rd_o`  out  5  write-back destination.
- `wb_data_o`  out  XLEN  write-back data.
- `instret_o`  out  CNT_W  count of retired instructions.

## Operation
- FSM states: RUN and WAIT.
- **RUN, non-load accept.** Condition: `ex_valid_i=1` and `ex_mem_read_i=0`. At the next edge, `wb_reg_write_o <= ex_reg_write_i & (ex_rd_i != 0)`, `wb_rd_o <= ex_rd_i`, `wb_data_o <= ex_result_i`, and `instret_o` increments. State stays RUN.
- **RUN, load accept.** Condition: `ex_valid_i=1` and `ex_mem_read_i=1`. Capture rd, reg_write, size, unsigned and lsb into internal registers, then go to WAIT. `wb_reg_write_o <= 0` at that edge.
- **RUN, nothing presented** (`ex_valid_i=0`): `wb_reg_write_o <= 0`.
- In every case where `wb_reg_write_o` goes to 0 without a new capture, `wb_rd_o` and `wb_data_o` hold their previous values.
- **WAIT.** `stall_o=1` for the whole state, including the cycle in which `dmem_rvalid_i` rises. `ex_valid_i` is ignored.
- **WAIT with `dmem_rvalid_i=1`.** At the edge, the aligned data goes to `wb_data_o`, the captured rd to `wb_rd_o`, and `wb_reg_write_o <= captured_reg_write & (captured_rd != 0)`. `instret_o` increments and the state returns to RUN.
- **WAIT without `dmem_rvalid_i`.** Outputs hold and `wb_reg_write_o=0`. There is no timeout.
- `dmem_rvalid_i` in RUN is ignored.
- **Load alignment:**
  - Byte: select `rdata[8*lsb +: 8]`.
  - Half: select `rdata[16*lsb[1] +: 16]`; `lsb[0]` is ignored.
  - Word: whole word; lsb is ignored.
  - Sign-extend from the selected MSB unless `unsigned=1`, which zero-extends.
- **rd = x0.** `wb_reg_write_o` is never asserted for rd=0. The forwarding unit does not check for x0, so this rule is mandatory.
- **Retirement counting.** Instructions with `ex_reg_write_i=0` (stores, branches) still retire and increment `instret_o`. `instret_o` wraps to 0 on overflow.

## Timing
- Reset values (any cycle with `rst_ni=0`):
  - State RUN.
  - `stall_o=0`, `wb_reg_write_o=0`, `wb_rd_o=0`, `wb_data_o=0`, `instret_o=0`.
  - Captured load fields cleared.
- Reset in WAIT abandons the load. A later `dmem_rvalid_i` is ignored because the block is back in RUN.
- `stall_o` is a decode of the state register only, with no combinational path from inputs. It is low in the first cycle after reset.
- Non-load latency: one cycle from EX accept to the `wb_*` pulse.
- Load latency: `wb_*` is valid in the cycle after `dmem_rvalid_i`.
  - Minimum is two cycles after accept, with rvalid in the first WAIT cycle.
  - Stall length equals the number of WAIT cycles.
- The instruction held in EX during WAIT sees the load result on `wb_*` in the first RUN cycle, so the forwarding unit resolves the load-use dependency without an extra bubble.
- Back-to-back non-loads retire one per cycle with no stall.

## Test plan
- **Reset.** Hold `rst_ni=0` for 3 cycles in the middle of traffic → all outputs 0, state RUN.
- **Back-to-back non-loads.** Issue x5=0x11, then x6=0x22, then x0=0x33 on consecutive cycles → `wb` pulses (5,0x11), (6,0x22); the third cycle shows `wb_reg_write_o=0` with `wb_rd_o=0`; `instret_o`=3.
- **Signed byte load.** LB, lsb=2, `rdata`=0x80FF_1234, rvalid 3 cycles after accept → `stall_o` high for 3 cycles, then `wb_data_o`=0xFFFF_FFFF (selected byte 0xFF) for one cycle, then `stall_o` low.
- **Halfword loads.** LHU, lsb=2, `rdata`=0x8001_0000 → 0x0000_8001. LH with the same inputs → 0xFFFF_8001.
- **Zero-wait load, load-use.** rvalid arrives in the first WAIT cycle, followed by a dependent ADD held in EX → `wb` carries the load result in the cycle the ADD is released; total stall is 1 cycle.
- **Reset mid-load, then counter wrap.** Reset in WAIT, then pulse `dmem_rvalid_i` → no `wb` pulse, `stall_o=0`. With `CNT_W`=4 and 16 retirements → `instret_o` wraps to 0.
